cell_scan_controller: RTL and testbench

- Sequences the 3x3 cell processor across a whole image for one instruction.
- Latches opcode and user input at start, then walks every valid cell window position in row-major order, issuing one cell request per position over a valid/ready handshake.
- Bounds in-flight requests with a credit counter.
- Collects in-order pixel results and generates row-major write addresses into the transmit image buffer.

---
 rtl/cell_scan_if.sv | 52 +++++
 rtl/cell_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_cell_scan_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_scan_if.sv
// Bundle between the scan controller and the 3x3 cell processor / tx image
// buffer: the request channel, the in-order result channel and the write port.
interface cell_scan_if #(
    parameter int CW       = 10,
    parameter int RW       = 9,
    parameter int OPCODE_W = 4,
    parameter int CH_W     = 8,
    parameter int PIX_W    = 24,
    parameter int AW       = 19
);
    logic                cell_req_valid;
    logic                cell_req_ready;
    logic [CW-1:0]       cell_col;
    logic [RW-1:0]       cell_row;
    logic [OPCODE_W-1:0] cell_opcode;
    logic [CH_W-1:0]     cell_user;
    logic                res_valid;
    logic [PIX_W-1:0]    res_pixel;
    logic                out_wr_en;
    logic [AW-1:0]       out_addr;
    logic [PIX_W-1:0]    out_pixel;

    // Controller side
    modport master (
        output cell_req_valid,
        input  cell_req_ready,
        output cell_col,
        output cell_row,
        output cell_opcode,
        output cell_user,
        input  res_valid,
        input  res_pixel,
        output out_wr_en,
        output out_addr,
        output out_pixel
    );

    // Processor / image buffer side
    modport slave (
        input  cell_req_valid,
        output cell_req_ready,
        input  cell_col,
        input  cell_row,
        input  cell_opcode,
        input  cell_user,
        output res_valid,
        output res_pixel,
        input  out_wr_en,
        input  out_addr,
        input  out_pixel
    );
endinterface

// File: rtl/cell_scan_controller.sv
// Walks every 3x3 window position of the image in row-major order for one
// instruction, issuing credit-limited cell requests and writing the in-order
// results to consecutive tx image buffer addresses.
module cell_scan_controller #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CELL_N   = 3,
    parameter int OPCODE_W = 4,
    parameter int CH_W     = 8,
    parameter int PIX_W    = 24,
    parameter int MAX_OUT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [CH_W-1:0]     user_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    cell_scan_if.master         bus
);
    localparam int OUT_W = IMG_W - CELL_N + 1;
    localparam int OUT_H = IMG_H - CELL_N + 1;
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    // Counters must be able to hold TOTAL itself, which AW bits may not.
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int OW    = $clog2(MAX_OUT + 1);

    // Highest legal opcode (AVG).
    localparam logic [OPCODE_W-1:0] OP_LAST   = OPCODE_W'(11);
    localparam logic [CW-1:0]       COL_LAST  = CW'(OUT_W - 1);
    localparam logic [CNT_W-1:0]    CNT_TOTAL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(TOTAL - 1);
    localparam logic [OW-1:0]       OUT_MAX   = OW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CH_W-1:0]     user_q, user_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CNT_W-1:0]    issue_q, issue_d;
    logic [CNT_W-1:0]    res_q, res_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [PIX_W-1:0]    pixel_q, pixel_d;
    logic                err_q, err_d;

    logic req_valid;
    logic req_fire;
    logic res_take;
    logic res_dec;

    // Credit gate: a new window is offered only while a slot is free.
    assign req_valid = (state_q == ISSUE) && (outst_q < OUT_MAX);
    assign req_fire  = req_valid && bus.cell_req_ready;
    // Results only count while an instruction is in flight.
    assign res_take  = bus.res_valid && ((state_q == ISSUE) || (state_q == DRAIN));
    assign res_dec   = res_take && (outst_q != '0);

    // Next-state, scan position, credit and result-path logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        user_d   = user_q;
        col_d    = col_q;
        row_d    = row_q;
        issue_d  = issue_q;
        res_d    = res_q;
        outst_d  = outst_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        pixel_d  = pixel_q;
        err_d    = 1'b0;

        if (req_fire && !res_dec) begin
            outst_d = outst_q + OW'(1);
        end else if (!req_fire && res_dec) begin
            outst_d = outst_q - OW'(1);
        end

        // Saturate at TOTAL so a stray result can never write past the image.
        if (res_take && (res_q != CNT_TOTAL)) begin
            wr_en_d = 1'b1;
            addr_d  = res_q[AW-1:0];
            pixel_d = bus.res_pixel;
            res_d   = res_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode <= OP_LAST) begin
                        opcode_d = opcode;
                        user_d   = user_in;
                        col_d    = '0;
                        row_d    = '0;
                        issue_d  = '0;
                        res_d    = '0;
                        outst_d  = '0;
                        state_d  = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    issue_d = issue_q + CNT_W'(1);
                    // The final position is held rather than advanced past the image.
                    if (issue_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (res_q == CNT_TOTAL) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            user_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            issue_q  <= '0;
            res_q    <= '0;
            outst_q  <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            pixel_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            user_q   <= user_d;
            col_q    <= col_d;
            row_q    <= row_d;
            issue_q  <= issue_d;
            res_q    <= res_d;
            outst_q  <= outst_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            pixel_q  <= pixel_d;
            err_q    <= err_d;
        end
    end

    assign busy = (state_q == ISSUE) || (state_q == DRAIN);
    assign done = (state_q == FINISH);
    assign err  = err_q;

    assign bus.cell_req_valid = req_valid;
    assign bus.cell_col       = col_q;
    assign bus.cell_row       = row_q;
    assign bus.cell_opcode    = opcode_q;
    assign bus.cell_user      = user_q;
    assign bus.out_wr_en      = wr_en_q;
    assign bus.out_addr       = addr_q;
    assign bus.out_pixel      = pixel_q;
endmodule

// File: tb/tb_cell_scan_controller.sv
// Bench for cell_scan_controller on a 5x4 image (3x2 window positions),
// with a cell processor model that returns results in order after a latency.
module tb_cell_scan_controller;
    localparam int IMG_W    = 5;
    localparam int IMG_H    = 4;
    localparam int CELL_N   = 3;
    localparam int OPCODE_W = 4;
    localparam int CH_W     = 8;
    localparam int PIX_W    = 24;
    localparam int MAX_OUT  = 2;
    localparam int OUT_W    = IMG_W - CELL_N + 1;
    localparam int OUT_H    = IMG_H - CELL_N + 1;
    localparam int TOTAL    = OUT_W * OUT_H;
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int AW       = $clog2(TOTAL);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [OPCODE_W-1:0] opcode = '0;
    logic [CH_W-1:0]     user_in = '0;
    logic                busy, done, err;

    cell_scan_if #(.CW(CW), .RW(RW), .OPCODE_W(OPCODE_W), .CH_W(CH_W),
                   .PIX_W(PIX_W), .AW(AW)) bus ();

    cell_scan_controller #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL_N(CELL_N),
                           .OPCODE_W(OPCODE_W), .CH_W(CH_W), .PIX_W(PIX_W),
                           .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .user_in(user_in), .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_FIN} mph_t;
    typedef struct {
        logic [OPCODE_W-1:0] op;
        logic [CH_W-1:0]     user;
        int                  lat;
        bit                  rr;
        bit                  exp_err;
        bit                  exp_busy;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    mph_t ph = M_IDLE;
    int fired = 0, wr_cnt = 0, outst = 0, done_cnt = 0;
    bit fin_pending = 0;
    logic [OPCODE_W-1:0] exp_op = '0;
    logic [CH_W-1:0]     exp_user = '0;
    int lat = 2;
    bit rand_ready = 0;
    int stall_idx = -1, stall_left = 0;
    bit force_res = 0;
    int due_q[$];
    logic [PIX_W-1:0] pix_q[$];
    vec_t tbl[7];

    // Result pixel the processor model produces for a window: tags everything
    // the request carried, so a wrong or reordered request shows up in the data.
    function automatic logic [PIX_W-1:0] mkpix(int c, int r, logic [OPCODE_W-1:0] op,
                                               logic [CH_W-1:0] u);
        return {op, u, 6'(r), 6'(c)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive processor inputs, predict the edge, then check outputs.
    task automatic step();
        mph_t ph0;
        bit fire, take, exp_valid, exp_wr, exp_err_n, accept;
        ph0 = ph;
        bus.res_valid = 1'b0;
        bus.res_pixel = '0;
        if (force_res) begin
            bus.res_valid = 1'b1;
            bus.res_pixel = 24'hABCDEF;
        end else if (pix_q.size() > 0 && due_q[0] <= cyc) begin
            bus.res_valid = 1'b1;
            bus.res_pixel = pix_q[0];
        end
        bus.cell_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ph0 == M_RUN && fired == stall_idx && stall_left > 0 && bus.cell_req_valid) begin
            bus.cell_req_ready = 1'b0;
            stall_left--;
            chk("stall_col", bus.cell_col, fired % OUT_W);
            chk("stall_row", bus.cell_row, fired / OUT_W);
            chk("stall_op", bus.cell_opcode, exp_op);
        end
        exp_valid = (ph0 == M_RUN) && (fired < TOTAL) && (outst < MAX_OUT);
        chk("req_valid", bus.cell_req_valid, exp_valid);
        fire = !reset && bus.cell_req_valid && bus.cell_req_ready;
        if (fire) begin
            chk("req_col", bus.cell_col, fired % OUT_W);
            chk("req_row", bus.cell_row, fired / OUT_W);
            chk("req_op", bus.cell_opcode, exp_op);
            chk("req_user", bus.cell_user, exp_user);
            due_q.push_back(cyc + lat);
            pix_q.push_back(mkpix(int'(bus.cell_col), int'(bus.cell_row),
                                  bus.cell_opcode, bus.cell_user));
            fired++;
            outst++;
        end
        if (bus.res_valid && !force_res) begin
            void'(due_q.pop_front());
            void'(pix_q.pop_front());
        end
        take   = !reset && bus.res_valid && (ph0 == M_RUN);
        exp_wr = take && (wr_cnt < TOTAL);
        if (take && outst > 0) outst--;
        exp_err_n = !reset && start && (ph0 == M_IDLE) && (opcode > 11);
        accept    = !reset && start && (ph0 == M_IDLE) && (opcode <= 11);
        if (reset) begin
            ph = M_IDLE;
            outst = 0;
            fin_pending = 0;
            due_q.delete();
            pix_q.delete();
            exp_op = '0;
            exp_user = '0;
        end else begin
            case (ph0)
                M_IDLE: if (accept) begin
                    ph = M_RUN; exp_op = opcode; exp_user = user_in;
                    fired = 0; wr_cnt = 0; outst = 0;
                end
                M_RUN: if (fin_pending) begin
                    ph = M_FIN; fin_pending = 0;
                end
                default: ph = M_IDLE;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("out_wr_en", bus.out_wr_en, exp_wr);
        if (exp_wr) begin
            if (bus.out_wr_en) begin
                chk("out_addr", bus.out_addr, wr_cnt);
                chk("out_pixel", bus.out_pixel,
                    mkpix(wr_cnt % OUT_W, wr_cnt / OUT_W, exp_op, exp_user));
            end
            wr_cnt++;
            if (wr_cnt == TOTAL) fin_pending = 1;
        end
        chk("busy", busy, ph == M_RUN);
        chk("done", done, ph == M_FIN);
        chk("err", err, exp_err_n);
        if (done) done_cnt++;
    endtask

    task automatic launch(input logic [OPCODE_W-1:0] op, input logic [CH_W-1:0] u);
        start = 1'b1; opcode = op; user_in = u;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while (ph != M_IDLE && n < budget) begin
            step();
            n++;
        end
        if (ph != M_IDLE) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: phase %0d after %0d cycles, required idle", ph, budget);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid"}, bus.cell_req_valid, 0);
        chk({tag, "_col"}, bus.cell_col, 0);
        chk({tag, "_row"}, bus.cell_row, 0);
        chk({tag, "_op"}, bus.cell_opcode, 0);
        chk({tag, "_user"}, bus.cell_user, 0);
        chk({tag, "_wr"}, bus.out_wr_en, 0);
        chk({tag, "_addr"}, bus.out_addr, 0);
        chk({tag, "_pix"}, bus.out_pixel, 0);
    endtask

    initial begin
        int d0, n;
        logic [OPCODE_W-1:0] rop;
        tbl[0] = '{4'd13, 8'h00, 2,  1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'd1,  8'h10, 2,  1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'd15, 8'h55, 2,  1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'd11, 8'hA5, 2,  1'b0, 1'b0, 1'b1};
        tbl[4] = '{4'd12, 8'h00, 2,  1'b0, 1'b1, 1'b0};
        tbl[5] = '{4'd0,  8'h3C, 10, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'd7,  8'h77, 3,  1'b1, 1'b0, 1'b1};
        bus.cell_req_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_pixel = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        step();
        reset = 1'b0;
        step();

        // Opcode table: illegal opcodes pulse err, legal ones run the whole image
        for (int i = 0; i < 7; i++) begin
            lat = tbl[i].lat;
            rand_ready = tbl[i].rr;
            d0 = done_cnt;
            launch(tbl[i].op, tbl[i].user);
            chk("tbl_err", err, tbl[i].exp_err);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            if (tbl[i].exp_busy) begin
                run_to_idle(300);
                chk("tbl_writes", wr_cnt, TOTAL);
                chk("tbl_done_pulses", done_cnt - d0, 1);
                chk("tbl_op_kept", bus.cell_opcode, tbl[i].op);
            end else begin
                step();
                chk("err_keeps_op", bus.cell_opcode, exp_op);
                chk("err_keeps_user", bus.cell_user, exp_user);
            end
        end
        rand_ready = 0;

        // Ready held low for 5 cycles on window (1,0)
        lat = 2;
        stall_idx = 1;
        stall_left = 5;
        launch(4'd1, 8'h10);
        run_to_idle(300);
        chk("stall_consumed", stall_left, 0);
        chk("stall_writes", wr_cnt, TOTAL);
        stall_idx = -1;

        // Start with SUB mid-run is ignored
        launch(4'd1, 8'h10);
        step(); step(); step();
        start = 1'b1; opcode = 4'd2; user_in = 8'hEE;
        step();
        start = 1'b0;
        chk("mid_start_op", bus.cell_opcode, 4'd1);
        chk("mid_start_user", bus.cell_user, 8'h10);
        run_to_idle(300);
        chk("mid_start_writes", wr_cnt, TOTAL);

        // Reset after three requests, stray result, then a clean run
        lat = 4;
        launch(4'd1, 8'h10);
        n = 0;
        while (fired < 3 && n < 100) begin step(); n++; end
        chk("three_issued", fired, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("midreset");
        force_res = 1'b1;
        step();
        force_res = 1'b0;
        step();
        chk("stray_no_write", bus.out_wr_en, 0);
        lat = 2;
        d0 = done_cnt;
        launch(4'd1, 8'h10);
        run_to_idle(300);
        chk("after_reset_writes", wr_cnt, TOTAL);
        chk("after_reset_done", done_cnt - d0, 1);

        // Randomized instructions, latencies and ready patterns
        for (int r = 0; r < 10; r++) begin
            rop = 4'($urandom_range(0, 15));
            lat = $urandom_range(1, 8);
            rand_ready = 1'($urandom_range(0, 1));
            d0 = done_cnt;
            launch(rop, 8'($urandom));
            if (ph == M_RUN) begin
                run_to_idle(400);
                chk("rand_writes", wr_cnt, TOTAL);
                chk("rand_done", done_cnt - d0, 1);
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
